gcd_stein_engine: RTL and testbench
===================================

Name: gcd_stein_engine

Overview:
Parametrised successor to the team's 16-bit GCD machine. Computes GCD(in1, in2) for any WIDTH using Stein's binary algorithm, so there is no divider or iterative subtract-only loop. Adds a busy/done handshake, defined zero-operand handling and an iteration counter for performance monitoring. Sits as a stand-alone arithmetic accelerator driven by a host FSM.

Parameters:
WIDTH, 16, operand and result width in bits (≥2)
CNT_W, 6, iteration-counter width; must hold 2*WIDTH+1 (counter saturates)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-low (asserted when 0, sampled on clk rising edge)
go  input  1  start request; sampled only in IDLE
in1  input  WIDTH  operand A, sampled with accepted go
in2  input  WIDTH  operand B, sampled with accepted go
out  output  WIDTH  GCD result, registered; held until next accepted go
done  output  1  one-cycle pulse: out valid
busy  output  1  high from cycle after go accepted until done cycle inclusive
zero_flag  output  1  registered with out: both operands were 0
iters  output  CNT_W  STRIP+LOOP cycles used by last operation, saturating; held with out

Behaviour:
- Reset (rst=0 at edge): state=IDLE; out=0, done=0, busy=0, zero_flag=0, iters=0; internal a, b, k, counter cleared. Reset mid-operation aborts it and produces no done.
- States: IDLE, CHECK, STRIP, LOOP, FINISH.
- IDLE: go=1 → latch a=in1, b=in2, k=0, cnt=0 → CHECK. go is ignored in every other state (no queueing).
- CHECK (1 cycle, no count):
  - a==0 && b==0 → res=0, zero_flag=1.
  - a==0 → res=b.
  - b==0 → res=a.
  - Each of the three cases above → FINISH.
  - Otherwise → STRIP.
- STRIP (count +1 per cycle):
  - a[0]==0 && b[0]==0 → a>>=1, b>>=1, k+=1, stay.
  - Else → LOOP with no data change.
- LOOP (count +1 per cycle), priority order:
  1. a[0]==0 → a>>=1.
  2. Else b[0]==0 → b>>=1.
  3. Else a==b → res=a<<k → FINISH.
  4. Else a>b → a=(a−b)>>1.
  5. Else b=(b−a)>>1.
- Arithmetic: subtraction is WIDTH-bit unsigned and never underflows because it is guarded by the compare. k needs clog2(WIDTH) bits. a<<k never overflows WIDTH, since the result ≤ min(in1, in2).
- FINISH (1 cycle): out=res, zero_flag, iters=cnt registered at entry; done=1 and busy=1 this cycle. Next state IDLE.
- Output timing: done rises in the cycle after FINISH is entered and lasts exactly one cycle. The next go may be sampled on the edge ending the done cycle at the earliest (state is IDLE then).
- Latency: zero-operand cases give done in the 3rd cycle after the go edge. Nonzero cases are bounded by 2*WIDTH+3 cycles go→done.
- Iteration counter saturates at 2^CNT_W−1 rather than wrapping.
- in1/in2 changes after go is accepted have no effect.

Decomposition:
- Shared package/include gcd_pkg: state encodings (IDLE=0, CHECK=1, STRIP=2, LOOP=3, FINISH=4, 3-bit), and a K_W = clog2(WIDTH) helper function.
- Keep the team's controller/datapath split. One sub-module, gcd_stein_datapath, holds:
  - a/b/k/res/cnt registers;
  - the compare (a_eq_b, a_gt_b, a_even, b_even, a_zero, b_zero);
  - the subtract-and-halve and final-shift logic.
- FSM stays in the top level.

Test Plan:
- WIDTH=16, go with in1=48, in2=18 → done pulse, out=6, zero_flag=0, busy high throughout, latency ≤35 cycles, iters≤33.
- in1=0, in2=35 → out=35 with done in 3rd cycle after go. in1=0, in2=0 → out=0, zero_flag=1.
- in1=32768, in2=16384 → out=16384 (k=14 path); in1=65535, in2=65535 → out=65535; in1=65535, in2=1 → out=1 within 35 cycles.
- Pulse go again while busy with in1=10, in2=4 → ignored; first result is unaffected; exactly one done.
- Drive rst=0 for one cycle mid-LOOP → next cycle busy=0, done=0, out=0. A new go with 21, 14 → out=7.
- WIDTH=32 build, in1=4294967294, in2=2147483647 → out=2147483647. Back-to-back ops (go on the edge after the done cycle) → each done=1 for a single cycle.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and helpers for the Stein GCD engine: controller state encoding
// and the width of the common-power-of-two shift counter.
package gcd_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    STRIP  = 3'd2,
    LOOP   = 3'd3,
    FINISH = 3'd4
  } state_t;

  // k counts shared factors of two; it never exceeds WIDTH-1.
  function automatic int k_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/gcd_stein_datapath.sv
// Operand registers, comparators and shift/subtract logic for Stein's binary GCD.
// The controller steers it through load, check, strip, loop and capture phases.
module gcd_stein_datapath
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             do_check,
  input  logic             do_strip,
  input  logic             do_loop,
  input  logic             capture,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             a_zero,
  output logic             b_zero,
  output logic             a_even,
  output logic             b_even,
  output logic             a_eq_b,
  output logic [WIDTH-1:0] out,
  output logic             zero_flag,
  output logic [CNT_W-1:0] iters
);

  localparam int K_W = k_width(WIDTH);

  logic [WIDTH-1:0] a, b, res;
  logic [K_W-1:0]   k;
  logic [CNT_W-1:0] cnt;
  logic             zf;
  logic             a_gt_b;
  logic [WIDTH-1:0] a_minus_b, b_minus_a;

  assign a_zero    = (a == '0);
  assign b_zero    = (b == '0);
  assign a_even    = ~a[0];
  assign b_even    = ~b[0];
  assign a_eq_b    = (a == b);
  assign a_gt_b    = (a > b);
  assign a_minus_b = a - b;
  assign b_minus_a = b - a;

  always_ff @(posedge clk) begin
    if (!rst) begin
      a         <= '0;
      b         <= '0;
      k         <= '0;
      res       <= '0;
      cnt       <= '0;
      zf        <= 1'b0;
      out       <= '0;
      zero_flag <= 1'b0;
      iters     <= '0;
    end else begin
      if (load) begin
        a   <= in1;
        b   <= in2;
        k   <= '0;
        cnt <= '0;
        zf  <= 1'b0;
      end else if (do_check) begin
        // Both-zero falls into the a_zero branch and yields res = b = 0.
        zf <= a_zero && b_zero;
        if (a_zero)
          res <= b;
        else if (b_zero)
          res <= a;
      end else if (do_strip) begin
        if (a_even && b_even) begin
          a <= a >> 1;
          b <= b >> 1;
          k <= k + K_W'(1);
        end
      end else if (do_loop) begin
        if (a_even)
          a <= a >> 1;
        else if (b_even)
          b <= b >> 1;
        else if (a_eq_b)
          res <= a << k;
        else if (a_gt_b)
          a <= a_minus_b >> 1;
        else
          b <= b_minus_a >> 1;
      end

      if ((do_strip || do_loop) && (cnt != {CNT_W{1'b1}}))
        cnt <= cnt + CNT_W'(1);

      if (capture) begin
        out       <= res;
        zero_flag <= zf;
        iters     <= cnt;
      end
    end
  end

endmodule

// File: rtl/gcd_stein_engine.sv
// Stein binary GCD accelerator with go/busy/done handshake; the controller FSM
// lives here and drives the gcd_stein_datapath sub-module.
module gcd_stein_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic             done,
  output logic             busy,
  output logic             zero_flag,
  output logic [CNT_W-1:0] iters
);

  state_t state, state_next;
  logic   done_q;
  logic   load, do_check, do_strip, do_loop, capture;
  logic   a_zero, b_zero, a_even, b_even, a_eq_b;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= (state == FINISH);
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    do_check   = 1'b0;
    do_strip   = 1'b0;
    do_loop    = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          load       = 1'b1;
          state_next = CHECK;
        end
      end
      CHECK: begin
        do_check   = 1'b1;
        state_next = (a_zero || b_zero) ? FINISH : STRIP;
      end
      STRIP: begin
        do_strip = 1'b1;
        if (!(a_even && b_even))
          state_next = LOOP;
      end
      LOOP: begin
        do_loop = 1'b1;
        if (!a_even && !b_even && a_eq_b)
          state_next = FINISH;
      end
      FINISH: begin
        capture    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The done cycle is already IDLE, so busy must also cover it explicitly.
  assign done = done_q;
  assign busy = (state != IDLE) || done_q;

  gcd_stein_datapath #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_datapath (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .do_check  (do_check),
    .do_strip  (do_strip),
    .do_loop   (do_loop),
    .capture   (capture),
    .in1       (in1),
    .in2       (in2),
    .a_zero    (a_zero),
    .b_zero    (b_zero),
    .a_even    (a_even),
    .b_even    (b_even),
    .a_eq_b    (a_eq_b),
    .out       (out),
    .zero_flag (zero_flag),
    .iters     (iters)
  );

endmodule

// File: tb/tb_gcd_stein_engine.sv
// Randomised self-checking bench for gcd_stein_engine at WIDTH=16 and WIDTH=32,
// compared against a Euclid-based GCD and an iteration-count reference.
module tb_gcd_stein_engine;

  logic        clk = 1'b0;
  logic        rst;

  logic        go16, done16, busy16, zf16;
  logic [15:0] in1_16, in2_16, out16;
  logic [5:0]  iters16;

  logic        go32, done32, busy32, zf32;
  logic [31:0] in1_32, in2_32, out32;
  logic [6:0]  iters32;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gcd_stein_engine #(.WIDTH(16), .CNT_W(6)) dut16 (
    .clk(clk), .rst(rst), .go(go16), .in1(in1_16), .in2(in2_16),
    .out(out16), .done(done16), .busy(busy16), .zero_flag(zf16), .iters(iters16)
  );

  gcd_stein_engine #(.WIDTH(32), .CNT_W(7)) dut32 (
    .clk(clk), .rst(rst), .go(go32), .in1(in1_32), .in2(in2_32),
    .out(out32), .done(done32), .busy(busy32), .zero_flag(zf32), .iters(iters32)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Euclid by remainder: a different route to the same answer as the engine.
  function automatic logic [63:0] gcd_ref(input logic [63:0] x, input logic [63:0] y);
    logic [63:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Cycles spent stripping common twos plus reduction steps, per Stein's rules.
  function automatic int iters_ref(input logic [63:0] x, input logic [63:0] y);
    int n;
    n = 0;
    if (x == 0 || y == 0) return 0;
    while (x[0] == 1'b0 && y[0] == 1'b0) begin
      x = x >> 1;
      y = y >> 1;
      n++;
    end
    n++;
    while (1'b1) begin
      n++;
      if (x[0] && y[0] && x == y) break;
      if (!x[0])       x = x >> 1;
      else if (!y[0])  y = y >> 1;
      else if (x > y)  x = (x - y) >> 1;
      else             y = (y - x) >> 1;
    end
    return n;
  endfunction

  function automatic logic cur_done(input int sel);
    return (sel == 32) ? done32 : done16;
  endfunction

  function automatic logic cur_busy(input int sel);
    return (sel == 32) ? busy32 : busy16;
  endfunction

  task automatic drive_go(input int sel, input logic g, input logic [31:0] x, input logic [31:0] y);
    if (sel == 32) begin
      go32 = g; in1_32 = x; in2_32 = y;
    end else begin
      go16 = g; in1_16 = x[15:0]; in2_16 = y[15:0];
    end
  endtask

  // Starts an operation at the current negedge and returns at the negedge of
  // the done cycle, so consecutive calls issue go back-to-back.
  task automatic applyStimulus(input int sel, input logic [31:0] x, input logic [31:0] y,
                               input bit poke);
    int          lat, w, limit, e_it, cw_max;
    bit          hit, busy_bad;
    logic [63:0] got_out, got_zf, got_it, e_out;
    w      = (sel == 32) ? 32 : 16;
    cw_max = (sel == 32) ? 127 : 63;
    limit  = 2 * w + 3;
    if (sel != 32) begin
      x = {16'h0, x[15:0]};
      y = {16'h0, y[15:0]};
    end
    e_out = gcd_ref({32'h0, x}, {32'h0, y});
    e_it  = iters_ref({32'h0, x}, {32'h0, y});
    drive_go(sel, 1'b1, x, y);
    @(negedge clk);
    drive_go(sel, 1'b0, $urandom, $urandom);
    hit      = 1'b0;
    busy_bad = 1'b0;
    for (lat = 1; lat <= limit; lat++) begin
      if (poke && lat == 3) drive_go(sel, 1'b1, 32'd10, 32'd4);
      if (poke && lat == 4) drive_go(sel, 1'b0, 32'd10, 32'd4);
      if (lat == 1) checkOutput("done_low_after_go", cur_done(sel), 1'b0);
      if (!cur_busy(sel)) busy_bad = 1'b1;
      if (cur_done(sel)) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    got_out = (sel == 32) ? {32'h0, out32} : {48'h0, out16};
    got_zf  = (sel == 32) ? {63'h0, zf32} : {63'h0, zf16};
    got_it  = (sel == 32) ? {57'h0, iters32} : {58'h0, iters16};
    checkOutput("done_seen", hit, 1'b1);
    checkOutput("out", got_out, e_out);
    checkOutput("zero_flag", got_zf, (x == 0 && y == 0));
    checkOutput("iters", got_it, (e_it > cw_max) ? cw_max : e_it);
    checkOutput("latency", lat, e_it + 3);
    checkOutput("busy_through", busy_bad, 1'b0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          dones;
    int          mode;
    logic [31:0] x, y, m;

    rst = 1'b0;
    drive_go(16, 1'b0, 0, 0);
    drive_go(32, 1'b0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_out16", out16, 0);
    checkOutput("rst_done16", done16, 0);
    checkOutput("rst_busy16", busy16, 0);
    checkOutput("rst_zf16", zf16, 0);
    checkOutput("rst_iters16", iters16, 0);
    checkOutput("rst_out32", out32, 0);
    checkOutput("rst_busy32", busy32, 0);

    $display("[TB] directed 16-bit cases");
    applyStimulus(16, 48, 18, 1'b1);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done16) dones++;
    end
    checkOutput("ignored_go_no_done", dones, 0);
    checkOutput("idle_after_op", busy16, 0);
    checkOutput("first_result_kept", out16, 6);

    applyStimulus(16, 0, 35, 1'b0);
    applyStimulus(16, 0, 0, 1'b0);
    applyStimulus(16, 35, 0, 1'b0);
    applyStimulus(16, 32768, 16384, 1'b0);
    applyStimulus(16, 65535, 65535, 1'b0);
    applyStimulus(16, 65535, 1, 1'b0);

    $display("[TB] reset during LOOP");
    drive_go(16, 1'b1, 65535, 1);
    @(negedge clk);
    drive_go(16, 1'b0, 0, 0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checkOutput("midrst_busy", busy16, 0);
    checkOutput("midrst_done", done16, 0);
    checkOutput("midrst_out", out16, 0);
    checkOutput("midrst_iters", iters16, 0);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done16) dones++;
    end
    checkOutput("midrst_no_done", dones, 0);
    applyStimulus(16, 21, 14, 1'b0);

    $display("[TB] random 16-bit cases");
    for (int i = 0; i < 24; i++) begin
      mode = $urandom_range(0, 3);
      m    = 32'd1 << $urandom_range(0, 6);
      x    = $urandom;
      y    = $urandom;
      if (mode == 1) begin
        x = $urandom_range(1, 300) * m;
        y = $urandom_range(1, 300) * m;
      end else if (mode == 2) begin
        if ($urandom_range(0, 1) == 0) x = 0; else y = 0;
      end else if (mode == 3) begin
        x = $urandom_range(0, 15);
        y = $urandom_range(0, 15);
      end
      applyStimulus(16, x, y, 1'b0);
    end

    $display("[TB] 32-bit cases");
    applyStimulus(32, 32'd4294967294, 32'd2147483647, 1'b0);
    applyStimulus(32, 32'd4294967295, 32'd1, 1'b0);
    applyStimulus(32, 32'h8000_0000, 32'h0000_4000, 1'b0);
    for (int i = 0; i < 12; i++) begin
      m = 32'd1 << $urandom_range(0, 12);
      x = $urandom;
      y = $urandom;
      if (i % 3 == 1) begin
        x = $urandom_range(1, 100000) * m;
        y = $urandom_range(1, 100000) * m;
      end
      applyStimulus(32, x, y, 1'b0);
    end
    @(negedge clk);
    checkOutput("done32_single_cycle", done32, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
